// File: rtl/bru_redir_ctrl_pkg.sv
// Shared types and redirect codes for the branch-mispredict recovery slice.
// BRU_REDIR_STAT_EN adds saturating statistics counters to bru_redir_ctrl.
package bru_redir_ctrl_pkg;

    typedef enum logic [1:0] {
        RDC_IDLE  = 2'd0,
        RDC_FLUSH = 2'd1,
        RDC_REDIR = 2'd2,
        RDC_DRAIN = 2'd3
    } rdc_state_e;

    localparam logic [1:0] REDIRJUMPOA = 2'b11;
    localparam logic [1:0] REDIRNO     = 2'b00;

    localparam int RDC_CNT_W = 4;

endpackage

// File: rtl/bru_redir_ctrl_if.sv
// BRU/ROB/frontend bundle seen by the redirect controller.
// BRU_REDIR_STAT_EN does not change this bundle.
interface bru_redir_ctrl_if #(
    parameter int PTR_W  = 6,
    parameter int ADDR_W = 32
);
    logic              BruCommitAble;
    logic [PTR_W-1:0]  BruCommitPtr;
    logic [1:0]        BruReDirType;
    logic [ADDR_W-1:0] BruReDirPc;
    logic [PTR_W-1:0]  RobHeadPtr;
    logic              ExcFlush;
    logic              FetchReDirAck;
    logic              BruFlash;
    logic              RobFlushAble;
    logic [PTR_W-1:0]  RobFlushPtr;
    logic              FetchReDirAble;
    logic [ADDR_W-1:0] FetchReDirPc;
    logic              IssueHold;

    modport master (
        output BruCommitAble, BruCommitPtr, BruReDirType,
        output BruReDirPc, RobHeadPtr, ExcFlush,
        output FetchReDirAck,
        input  BruFlash, RobFlushAble, RobFlushPtr,
        input  FetchReDirAble, FetchReDirPc, IssueHold
    );

    modport slave (
        input  BruCommitAble, BruCommitPtr, BruReDirType,
        input  BruReDirPc, RobHeadPtr, ExcFlush,
        input  FetchReDirAck,
        output BruFlash, RobFlushAble, RobFlushPtr,
        output FetchReDirAble, FetchReDirPc, IssueHold
    );
endinterface

// File: rtl/bru_redir_ctrl_age_cmp.sv
// rob_age_cmp: "a strictly older than b" relative to the ROB head.
// Pure combinational; shared with the LSU and ROB.
module rob_age_cmp #(
    parameter int PTR_W = 6
) (
    input  logic [PTR_W-1:0] head,
    input  logic [PTR_W-1:0] a,
    input  logic [PTR_W-1:0] b,
    output logic             older
);
    logic [PTR_W-1:0] age_a;
    logic [PTR_W-1:0] age_b;

    // modular subtraction keeps the compare correct across pointer wrap
    assign age_a = a - head;
    assign age_b = b - head;
    assign older = age_a < age_b;
endmodule

// File: rtl/bru_redir_ctrl.sv
// Branch-mispredict recovery sequencer: flush, ROB truncate, fetch redirect, drain.
// Define BRU_REDIR_STAT_EN to add StatMispredCnt / StatRecoverCyc outputs.
module bru_redir_ctrl
    import bru_redir_ctrl_pkg::*;
#(
    parameter int PTR_W       = 6,
    parameter int ADDR_W      = 32,
    parameter int RECOVER_CYC = 2
) (
    input  logic        Clk,
    input  logic        Rest,
`ifdef BRU_REDIR_STAT_EN
    output logic [31:0] StatMispredCnt,
    output logic [31:0] StatRecoverCyc,
`endif
    bru_redir_ctrl_if.slave bus
);
    rdc_state_e             state_q, state_d;
    logic [PTR_W-1:0]       CapPtr, cap_ptr_d;
    logic [ADDR_W-1:0]      CapPc, cap_pc_d;
    logic [RDC_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   ev;
    logic                   ev_older;
    logic                   cap_en;

    assign ev = bus.BruCommitAble
              & (bus.BruReDirType == REDIRJUMPOA);

    rob_age_cmp #(
        .PTR_W (PTR_W)
    ) u_age (
        .head  (bus.RobHeadPtr),
        .a     (bus.BruCommitPtr),
        .b     (CapPtr),
        .older (ev_older)
    );

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            state_q <= RDC_IDLE;
            CapPtr  <= '0;
            CapPc   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            CapPtr  <= cap_ptr_d;
            CapPc   <= cap_pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_ptr_d = CapPtr;
        cap_pc_d  = CapPc;
        cnt_d     = cnt_q;
        cap_en    = 1'b0;
        if (bus.ExcFlush) begin
            state_d = RDC_IDLE;
            cnt_d   = '0;
        end else if (ev && (state_q == RDC_IDLE || ev_older)) begin
            // an older branch overrides any progress, even a same-cycle ack
            cap_en    = 1'b1;
            cap_ptr_d = bus.BruCommitPtr;
            cap_pc_d  = bus.BruReDirPc;
            state_d   = RDC_FLUSH;
        end else begin
            unique case (state_q)
                RDC_IDLE: ;
                RDC_FLUSH: state_d = RDC_REDIR;
                RDC_REDIR: begin
                    if (bus.FetchReDirAck) begin
                        cnt_d   = RDC_CNT_W'(RECOVER_CYC);
                        state_d = RDC_DRAIN;
                    end
                end
                RDC_DRAIN: begin
                    if (cnt_q <= RDC_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = RDC_IDLE;
                    end else begin
                        cnt_d = cnt_q - RDC_CNT_W'(1);
                    end
                end
                default: state_d = RDC_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.BruFlash       = 1'b0;
        bus.RobFlushAble   = 1'b0;
        bus.RobFlushPtr    = '0;
        bus.FetchReDirAble = 1'b0;
        bus.FetchReDirPc   = '0;
        bus.IssueHold      = 1'b0;
        unique case (state_q)
            RDC_IDLE: ;
            RDC_FLUSH: begin
                bus.BruFlash     = 1'b1;
                bus.RobFlushAble = 1'b1;
                bus.RobFlushPtr  = CapPtr;
                bus.IssueHold    = 1'b1;
            end
            RDC_REDIR: begin
                bus.FetchReDirAble = 1'b1;
                bus.FetchReDirPc   = CapPc;
                bus.IssueHold      = 1'b1;
            end
            RDC_DRAIN: bus.IssueHold = 1'b1;
            default: ;
        endcase
    end

`ifdef BRU_REDIR_STAT_EN
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            StatMispredCnt <= '0;
            StatRecoverCyc <= '0;
        end else begin
            if (cap_en && StatMispredCnt != '1)
                StatMispredCnt <= StatMispredCnt + 32'd1;
            if (state_q != RDC_IDLE && StatRecoverCyc != '1)
                StatRecoverCyc <= StatRecoverCyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bru_redir_ctrl.sv
// Directed bench for bru_redir_ctrl with hand-computed expectations.
// Builds with or without BRU_REDIR_STAT_EN.
module tb_bru_redir_ctrl;
    import bru_redir_ctrl_pkg::*;

    logic Clk;
    logic Rest;
    int   nvec;
    int   nerr;

    bru_redir_ctrl_if #(.PTR_W(6), .ADDR_W(32)) bus ();

`ifdef BRU_REDIR_STAT_EN
    logic [31:0] stat_mis;
    logic [31:0] stat_cyc;
`endif

    bru_redir_ctrl #(
        .PTR_W       (6),
        .ADDR_W      (32),
        .RECOVER_CYC (2)
    ) dut (
        .Clk            (Clk),
        .Rest           (Rest),
`ifdef BRU_REDIR_STAT_EN
        .StatMispredCnt (stat_mis),
        .StatRecoverCyc (stat_cyc),
`endif
        .bus            (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag,
                        input logic bf, input logic rfa,
                        input logic [5:0] rfp, input logic fra,
                        input logic [31:0] frp, input logic ih);
        chk({tag, ".flash"}, 64'(bus.BruFlash), 64'(bf));
        chk({tag, ".robfa"}, 64'(bus.RobFlushAble), 64'(rfa));
        chk({tag, ".robfp"}, 64'(bus.RobFlushPtr), 64'(rfp));
        chk({tag, ".fra"}, 64'(bus.FetchReDirAble), 64'(fra));
        chk({tag, ".frpc"}, 64'(bus.FetchReDirPc), 64'(frp));
        chk({tag, ".hold"}, 64'(bus.IssueHold), 64'(ih));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ev(input logic [5:0] p, input logic [31:0] pc);
        bus.BruCommitAble = 1'b1;
        bus.BruReDirType  = REDIRJUMPOA;
        bus.BruCommitPtr  = p;
        bus.BruReDirPc    = pc;
    endtask

    task automatic noev();
        bus.BruCommitAble = 1'b0;
        bus.BruReDirType  = REDIRNO;
        bus.BruCommitPtr  = '0;
        bus.BruReDirPc    = '0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        Rest = 1'b1;
        noev();
        bus.RobHeadPtr    = '0;
        bus.ExcFlush      = 1'b0;
        bus.FetchReDirAck = 1'b0;
        #3;
        outs("rst", 0, 0, 0, 0, 0, 0);
        #9 Rest = 1'b0;
        tick();
        outs("rst_idle", 0, 0, 0, 0, 0, 0);

        // 1: basic recovery
        ev(6'd5, 32'h1C00_0040);
        tick();
        noev();
        outs("t1_flush", 1, 1, 5, 0, 0, 1);
        tick();
        outs("t1_redir1", 0, 0, 0, 1, 32'h1C00_0040, 1);
        tick();
        outs("t1_redir2", 0, 0, 0, 1, 32'h1C00_0040, 1);
        tick();
        outs("t1_redir3", 0, 0, 0, 1, 32'h1C00_0040, 1);
        bus.FetchReDirAck = 1'b1;
        tick();
        bus.FetchReDirAck = 1'b0;
        outs("t1_drain1", 0, 0, 0, 0, 0, 1);
        tick();
        outs("t1_drain2", 0, 0, 0, 0, 0, 1);
        tick();
        outs("t1_idle", 0, 0, 0, 0, 0, 0);

        // 2: older override in REDIR, same-cycle ack abandoned
        bus.RobHeadPtr = 6'd4;
        ev(6'd10, 32'h0000_1000);
        tick();
        noev();
        outs("t2_flush", 1, 1, 10, 0, 0, 1);
        tick();
        outs("t2_redir", 0, 0, 0, 1, 32'h0000_1000, 1);
        ev(6'd7, 32'h0000_2000);
        bus.FetchReDirAck = 1'b1;
        tick();
        noev();
        bus.FetchReDirAck = 1'b0;
        outs("t2_reflush", 1, 1, 7, 0, 0, 1);
        tick();
        outs("t2_redir_b", 0, 0, 0, 1, 32'h0000_2000, 1);
        ev(6'd12, 32'h0000_3000);
        tick();
        noev();
        outs("t2_young", 0, 0, 0, 1, 32'h0000_2000, 1);
        bus.FetchReDirAck = 1'b1;
        tick();
        bus.FetchReDirAck = 1'b0;
        tick();
        tick();
        outs("t2_idle", 0, 0, 0, 0, 0, 0);

        // 3: wrap-around age with head=60
        bus.RobHeadPtr = 6'd60;
        ev(6'd2, 32'h0000_4000);
        tick();
        noev();
        outs("t3_flush", 1, 1, 2, 0, 0, 1);
        tick();
        ev(6'd62, 32'h0000_5000);
        tick();
        outs("t3_override", 1, 1, 62, 0, 0, 1);
        ev(6'd3, 32'h0000_6000);
        tick();
        noev();
        outs("t3_young", 0, 0, 0, 1, 32'h0000_5000, 1);
        bus.FetchReDirAck = 1'b1;
        tick();
        bus.FetchReDirAck = 1'b0;
        tick();
        tick();
        outs("t3_idle", 0, 0, 0, 0, 0, 0);

        // 4: non-mispredict redirect types never start recovery
        bus.RobHeadPtr = '0;
        for (int i = 0; i < 6; i++) begin
            bus.BruCommitAble = 1'b1;
            bus.BruReDirType  = 2'(i % 3);
            bus.BruCommitPtr  = 6'(i + 1);
            bus.BruReDirPc    = 32'h0000_7000 + 32'(i);
            tick();
            outs("t4_quiet", 0, 0, 0, 0, 0, 0);
        end
        noev();

        // 5: exception beats a same-cycle older event and ack
        ev(6'd20, 32'h0000_0100);
        tick();
        noev();
        tick();
        outs("t5_redir", 0, 0, 0, 1, 32'h0000_0100, 1);
        bus.ExcFlush      = 1'b1;
        bus.FetchReDirAck = 1'b1;
        ev(6'd3, 32'h0000_0200);
        tick();
        bus.ExcFlush      = 1'b0;
        bus.FetchReDirAck = 1'b0;
        noev();
        outs("t5_exc", 0, 0, 0, 0, 0, 0);
        tick();
        outs("t5_after", 0, 0, 0, 0, 0, 0);

        // 6: asynchronous reset in DRAIN, then a clean recovery
        ev(6'd9, 32'h0000_0300);
        tick();
        noev();
        tick();
        bus.FetchReDirAck = 1'b1;
        tick();
        bus.FetchReDirAck = 1'b0;
        outs("t6_drain", 0, 0, 0, 0, 0, 1);
        #2 Rest = 1'b1;
        #1;
        outs("t6_async", 0, 0, 0, 0, 0, 0);
        #2 Rest = 1'b0;
        tick();
        outs("t6_rel", 0, 0, 0, 0, 0, 0);
        ev(6'd1, 32'h1C00_0080);
        tick();
        noev();
        outs("t6_flush", 1, 1, 1, 0, 0, 1);
        tick();
        outs("t6_redir", 0, 0, 0, 1, 32'h1C00_0080, 1);
        bus.FetchReDirAck = 1'b1;
        tick();
        bus.FetchReDirAck = 1'b0;
        outs("t6_drain1", 0, 0, 0, 0, 0, 1);
        tick();
        outs("t6_drain2", 0, 0, 0, 0, 0, 1);
        tick();
        outs("t6_idle", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
